// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size encodings, sequencer states and reset instruction
package mem_access_pkg;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;
   localparam logic [31:0] NOP = 32'h0000_0013;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte enables, store lane replication and load shift/extend
module lsu_lane_align
   import mem_access_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int BW = XLEN / 8,
   localparam int LW = $clog2(BW)
) (
   input  logic [1:0]      size,
   input  logic            uns,
   input  logic [LW-1:0]   lane,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] bus_rdata,
   output logic [BW-1:0]   be,
   output logic [XLEN-1:0] wrep,
   output logic [XLEN-1:0] load
);
   logic [XLEN-1:0] sh;
   always_comb begin
      sh = bus_rdata >> {lane, 3'b000};
      be = size == SZ_D ? {BW{1'b1}} :
           (size == SZ_W ? BW'(4'hF) : size == SZ_H ? BW'(2'b11) : BW'(1'b1)) << lane;
      wrep = size == SZ_B ? {BW{wdata[7:0]}} :
             size == SZ_H ? {(XLEN/16){wdata[15:0]}} :
             size == SZ_W ? {(XLEN/32){wdata[31:0]}} : wdata;
      // signed casts sign-extend to XLEN, unsigned casts zero-extend
      load = size == SZ_B ? (uns ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]))) :
             size == SZ_H ? (uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]))) :
             size == SZ_W ? (uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]))) : sh;
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: serialises fetch and load/store onto one req/gnt/rvalid bus
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int          XLEN    = 32,
   parameter int          TIMEOUT = 16,
   parameter logic [31:0] IR_RST  = NOP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [1:0]        data_size,
   input  logic              data_uns,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   wdata,
   output logic [31:0]       instr,
   output logic [XLEN-1:0]   rdata,
   output logic              done,
   output logic              err,
   output logic              misalign,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int BW = XLEN / 8;
   localparam int LW = $clog2(BW);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

   state_t          state, nxt;
   logic [XLEN-1:0] a_addr, a_wdata, ld;
   logic [1:0]      a_size, req_size;
   logic            a_we, a_uns, a_fetch;
   logic [CW-1:0]   cnt;
   logic [BW-1:0]   be;
   logic            acc, bad, to_hit, fin, abort;

   lsu_lane_align #(.XLEN(XLEN)) u_align (
      .size      (a_size),
      .uns       (a_uns),
      .lane      (a_addr[LW-1:0]),
      .wdata     (a_wdata),
      .bus_rdata (mem_rdata),
      .be        (be),
      .wrep      (mem_wdata),
      .load      (ld)
   );

   always_comb begin
      acc      = state == IDLE && (data_req || fetch_req);
      req_size = data_req ? data_size : SZ_W;
      bad      = (req_size == SZ_H && addr[0]) ||
                 (req_size == SZ_W && addr[1:0] != 2'b00) ||
                 (req_size == SZ_D && (XLEN == 32 || addr[2:0] != 3'b000));
      to_hit   = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
      fin      = state == WAIT && mem_rvalid;
      abort    = to_hit && ((state == REQ && !mem_gnt) || (state == WAIT && !mem_rvalid));
      nxt      = state;
      nxt      = state == IDLE ? (acc && !bad ? REQ : IDLE) :
                 state == REQ  ? (mem_gnt ? WAIT : abort ? IDLE : REQ) :
                 (fin || abort) ? IDLE : WAIT;
      busy     = state != IDLE;
      mem_req  = state == REQ;
      mem_we   = busy && a_we;
      mem_be   = busy ? be : '0;
      mem_addr = {a_addr[XLEN-1:LW], LW'(0)};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         a_addr   <= '0;
         a_wdata  <= '0;
         a_size   <= SZ_B;
         a_we     <= 1'b0;
         a_uns    <= 1'b0;
         a_fetch  <= 1'b0;
         instr    <= IR_RST;
         rdata    <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         misalign <= 1'b0;
      end else begin
         state    <= nxt;
         done     <= fin;
         err      <= abort;
         misalign <= acc && bad;
         cnt      <= acc ? '0 : busy ? cnt + CW'(1) : cnt;
         if (acc && !bad) begin
            a_addr  <= addr;
            a_size  <= req_size;
            a_we    <= data_req && data_we;
            a_uns   <= data_uns;
            a_wdata <= data_req ? wdata : '0;
            a_fetch <= !data_req;
         end
         if (fin && a_fetch) instr <= ld[31:0];
         if (fin && !a_fetch && !a_we) rdata <= ld;
      end
   end
endmodule
